// File: rtl/limit_intl_multi.sv
// Multi-channel signed limit interlock: per-channel over/under compare, persistence counting, sticky flags.
// Define LIMIT_INTL_FIRST_FAULT_EN to build the first-fault capture register.
module limit_intl_lane #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 valid,
  input  logic                 s1_valid,
  input  logic                 clr,
  input  logic signed [DW-1:0] data,
  input  logic signed [DW-1:0] over_sp,
  input  logic signed [DW-1:0] under_sp,
  input  logic                 over_en,
  input  logic                 under_en,
  input  logic [CW-1:0]        thr,
  output logic                 ov_set,
  output logic                 un_set,
  output logic                 over_flag,
  output logic                 under_flag
);
  logic          ov, un;
  logic [CW-1:0] ov_cnt, un_cnt, ov_nxt, un_nxt;

  // Saturating count; the >= test lets a lowered threshold trip on the next violation.
  function automatic logic [CW-1:0] cnt_step(input logic v, input logic [CW-1:0] c,
                                             input logic [CW-1:0] t);
    if (!v) return '0;
    if (c >= t) return t;
    return c + 1'b1;
  endfunction

  assign ov_nxt = cnt_step(ov, ov_cnt, thr);
  assign un_nxt = cnt_step(un, un_cnt, thr);
  assign ov_set = s1_valid && ov && (ov_nxt == thr);
  assign un_set = s1_valid && un && (un_nxt == thr);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ov         <= 1'b0;
      un         <= 1'b0;
      ov_cnt     <= '0;
      un_cnt     <= '0;
      over_flag  <= 1'b0;
      under_flag <= 1'b0;
    end else begin
      if (valid) begin
        ov <= over_en  && (data > over_sp);
        un <= under_en && (data < under_sp);
      end
      if (clr)           ov_cnt <= '0;
      else if (s1_valid) ov_cnt <= ov_nxt;
      if (clr)           un_cnt <= '0;
      else if (s1_valid) un_cnt <= un_nxt;
      if (ov_set)   over_flag  <= 1'b1;
      else if (clr) over_flag  <= 1'b0;
      if (un_set)   under_flag <= 1'b1;
      else if (clr) under_flag <= 1'b0;
    end
  end
endmodule

module limit_intl_multi #(
  parameter int N_CH = 4,
  parameter int DW   = 32,
  parameter int CW   = 8,
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_CH*DW-1:0]   i_data,
  input  logic                 i_valid,
  input  logic [N_CH*DW-1:0]   i_over_sp,
  input  logic [N_CH*DW-1:0]   i_under_sp,
  input  logic [N_CH-1:0]      i_over_en,
  input  logic [N_CH-1:0]      i_under_en,
  input  logic [CW-1:0]        i_persist,
  input  logic                 i_clr,
  output logic [N_CH-1:0]      o_over_flag,
  output logic [N_CH-1:0]      o_under_flag,
  output logic                 o_intl,
  output logic [CHW-1:0]       o_first_ch,
  output logic                 o_first_type,
  output logic                 o_first_valid
);
  logic [N_CH-1:0][DW-1:0] data_a, osp_a, usp_a;
  logic [N_CH-1:0]         ov_set, un_set;
  logic [1:0]              vld_pipe;
  logic [CW-1:0]           thr;

  assign data_a = i_data;
  assign osp_a  = i_over_sp;
  assign usp_a  = i_under_sp;
  assign thr    = (i_persist == '0) ? CW'(1) : i_persist;
  assign vld_pipe[0] = i_valid;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) vld_pipe[1] <= 1'b0;
    else        vld_pipe[1] <= vld_pipe[0];
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    limit_intl_lane #(.DW(DW), .CW(CW)) u_lane (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .valid      (vld_pipe[0]),
      .s1_valid   (vld_pipe[1]),
      .clr        (i_clr),
      .data       (data_a[k]),
      .over_sp    (osp_a[k]),
      .under_sp   (usp_a[k]),
      .over_en    (i_over_en[k]),
      .under_en   (i_under_en[k]),
      .thr        (thr),
      .ov_set     (ov_set[k]),
      .un_set     (un_set[k]),
      .over_flag  (o_over_flag[k]),
      .under_flag (o_under_flag[k])
    );
  end

  assign o_intl = |{o_over_flag, o_under_flag};

`ifdef LIMIT_INTL_FIRST_FAULT_EN
  logic [N_CH-1:0] new_ov, new_un;
  logic [CHW-1:0]  cap_ch;
  logic            cap_type, any_new;

  assign new_ov  = ov_set & ~o_over_flag;
  assign new_un  = un_set & ~o_under_flag;
  assign any_new = |{new_ov, new_un};

  // Descending scan so the lowest channel wins; over beats under within a channel.
  always_comb begin
    cap_ch   = '0;
    cap_type = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (new_ov[k]) begin
        cap_ch   = CHW'(k);
        cap_type = 1'b1;
      end else if (new_un[k]) begin
        cap_ch   = CHW'(k);
        cap_type = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_first_ch    <= '0;
      o_first_type  <= 1'b0;
      o_first_valid <= 1'b0;
    end else if ((i_clr || !o_first_valid) && any_new) begin
      o_first_ch    <= cap_ch;
      o_first_type  <= cap_type;
      o_first_valid <= 1'b1;
    end else if (i_clr) begin
      o_first_ch    <= '0;
      o_first_type  <= 1'b0;
      o_first_valid <= 1'b0;
    end
  end
`else
  logic unused_set;
  assign unused_set    = ^{ov_set, un_set};
  assign o_first_ch    = '0;
  assign o_first_type  = 1'b0;
  assign o_first_valid = 1'b0;
`endif
endmodule

// File: tb/tb_limit_intl_multi.sv
// Randomized + directed bench for limit_intl_multi with a queue-based scoreboard and behavioural model.
module tb_limit_intl_multi;
  localparam int N_CH = 4;
  localparam int DW   = 32;
  localparam int CW   = 8;
`ifdef LIMIT_INTL_FIRST_FAULT_EN
  localparam bit FF = 1'b1;
`else
  localparam bit FF = 1'b0;
`endif

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b0;
  logic [N_CH*DW-1:0]   i_data = '0, i_over_sp = '0, i_under_sp = '0;
  logic                 i_valid = 1'b0, i_clr = 1'b0;
  logic [N_CH-1:0]      i_over_en = '0, i_under_en = '0;
  logic [CW-1:0]        i_persist = '0;
  logic [N_CH-1:0]      o_over_flag, o_under_flag;
  logic                 o_intl, o_first_type, o_first_valid;
  logic [1:0]           o_first_ch;

  limit_intl_multi #(.N_CH(N_CH), .DW(DW), .CW(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .i_over_sp(i_over_sp), .i_under_sp(i_under_sp), .i_over_en(i_over_en),
    .i_under_en(i_under_en), .i_persist(i_persist), .i_clr(i_clr),
    .o_over_flag(o_over_flag), .o_under_flag(o_under_flag), .o_intl(o_intl),
    .o_first_ch(o_first_ch), .o_first_type(o_first_type), .o_first_valid(o_first_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [N_CH-1:0] ov, un;
    logic            intl;
    logic [1:0]      fch;
    logic            ft, fv;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;
  bit   active = 0;

  // stimulus state
  int          dat[N_CH], osp[N_CH], usp[N_CH];
  logic [N_CH-1:0] oen, uen;
  int          pers;
  bit          rst;

  // reference model state
  int  ocnt[N_CH], ucnt[N_CH];
  bit  oflag[N_CH], uflag[N_CH], p_ov[N_CH], p_un[N_CH];
  bit  p_valid, m_fv, m_ft;
  int  m_fch;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit v, input bit c, output exp_t e);
    int thr;
    bit seto[N_CH], setu[N_CH], newo[N_CH], newu[N_CH];
    bit any;
    if (!rst) begin
      for (int k = 0; k < N_CH; k++) begin
        ocnt[k] = 0; ucnt[k] = 0; oflag[k] = 0; uflag[k] = 0; p_ov[k] = 0; p_un[k] = 0;
      end
      p_valid = 0; m_fv = 0; m_ft = 0; m_fch = 0;
    end else begin
      thr = (pers == 0) ? 1 : pers;
      any = 0;
      for (int k = 0; k < N_CH; k++) begin
        seto[k] = 0; setu[k] = 0;
        if (p_valid) begin
          ocnt[k] = p_ov[k] ? ((ocnt[k] + 1 > thr) ? thr : ocnt[k] + 1) : 0;
          ucnt[k] = p_un[k] ? ((ucnt[k] + 1 > thr) ? thr : ucnt[k] + 1) : 0;
          seto[k] = p_ov[k] && (ocnt[k] == thr);
          setu[k] = p_un[k] && (ucnt[k] == thr);
        end
        newo[k] = seto[k] && !oflag[k];
        newu[k] = setu[k] && !uflag[k];
        any = any || newo[k] || newu[k];
      end
      if (FF) begin
        if ((c || !m_fv) && any) begin
          m_fv = 1;
          for (int k = N_CH - 1; k >= 0; k--) begin
            if (newo[k]) begin m_fch = k; m_ft = 1; end
            else if (newu[k]) begin m_fch = k; m_ft = 0; end
          end
        end else if (c) begin
          m_fv = 0; m_fch = 0; m_ft = 0;
        end
      end
      for (int k = 0; k < N_CH; k++) begin
        oflag[k] = seto[k] || (!c && oflag[k]);
        uflag[k] = setu[k] || (!c && uflag[k]);
        if (c) begin ocnt[k] = 0; ucnt[k] = 0; end
      end
      p_valid = v;
      if (v) for (int k = 0; k < N_CH; k++) begin
        p_ov[k] = oen[k] && (dat[k] > osp[k]);
        p_un[k] = uen[k] && (dat[k] < usp[k]);
      end
    end
    e = '0;
    for (int k = 0; k < N_CH; k++) begin
      e.ov[k] = oflag[k];
      e.un[k] = uflag[k];
      e.intl  = e.intl | oflag[k] | uflag[k];
    end
    e.fch = 2'(m_fch);
    e.ft  = m_ft;
    e.fv  = m_fv;
  endtask

  task automatic drive(input bit v, input bit c);
    exp_t e;
    @(negedge i_clk);
    i_rst = rst; i_valid = v; i_clr = c;
    i_over_en = oen; i_under_en = uen; i_persist = CW'(pers);
    for (int k = 0; k < N_CH; k++) begin
      i_data[k*DW +: DW]     = DW'(dat[k]);
      i_over_sp[k*DW +: DW]  = DW'(osp[k]);
      i_under_sp[k*DW +: DW] = DW'(usp[k]);
    end
    model_step(v, c, e);
    q.push_back(e);
    active = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0);
  endtask

  // monitor: DUT outputs are presented every cycle; one expectation per cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("over_flag",   int'(o_over_flag),   int'(e.ov));
        chk("under_flag",  int'(o_under_flag),  int'(e.un));
        chk("intl",        int'(o_intl),        int'(e.intl));
        chk("first_ch",    int'(o_first_ch),    int'(e.fch));
        chk("first_type",  int'(o_first_type),  int'(e.ft));
        chk("first_valid", int'(o_first_valid), int'(e.fv));
      end else if (active) begin
        chk("scoreboard_empty", 0, 1);
      end
    end
  end

  initial begin
    rst = 0; pers = 1; oen = '1; uen = '1;
    for (int k = 0; k < N_CH; k++) begin dat[k] = 0; osp[k] = 2000; usp[k] = -2000; end
    osp[1] = 1000; usp[0] = -500;
    idle(2);
    rst = 1;
    idle(2);
    // single-sample trip on ch1, then equality is not a violation
    dat[1] = 1001; drive(1, 0); dat[1] = 0; idle(3);
    drive(0, 1); idle(1);
    dat[1] = 1000; drive(1, 0); dat[1] = 0; idle(3);
    // persistence 3 on ch0 under with a break and valid gaps
    pers = 3;
    dat[0] = -501; drive(1, 0); idle(1); drive(1, 0);
    dat[0] = -400; drive(1, 0);
    dat[0] = -501; drive(1, 0); idle(2); drive(1, 0); drive(1, 0);
    dat[0] = 0; idle(3);
    drive(0, 1); idle(1);
    // clear coincident with the trip edge
    pers = 1;
    dat[1] = 1001; drive(1, 0); dat[1] = 0; drive(0, 1); idle(2);
    drive(0, 1); idle(1);
    // ch2 over disabled, then latched flag survives disable
    oen[2] = 0; dat[2] = 5000; drive(1, 0); drive(1, 0); drive(1, 0); idle(3);
    oen[2] = 1; drive(1, 0); idle(1);
    oen[2] = 0; drive(1, 0); idle(3);
    dat[2] = 0; oen[2] = 1; drive(0, 1); idle(1);
    // simultaneous ch3 over and ch1 under, then a later ch0 trip
    usp[1] = -500;
    dat[3] = 5000; dat[1] = -5000; drive(1, 0); dat[3] = 0; dat[1] = 0; idle(3);
    dat[0] = 5000; drive(1, 0); dat[0] = 0; idle(3);
    drive(0, 1); idle(1);
    // reset with counters at 2 of 3 and a sample in stage 1
    pers = 3; dat[0] = 5000;
    drive(1, 0); drive(1, 0); drive(1, 0);
    rst = 0; idle(2); rst = 1;
    drive(1, 0); dat[0] = 0; idle(4);
    // randomized phase
    for (int k = 0; k < N_CH; k++) begin osp[k] = 1000; usp[k] = -500; end
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) pers = $urandom_range(0, 4);
      if (i % 25 == 0) begin oen = 4'($urandom_range(0, 15)) | 4'b1001; uen = 4'($urandom_range(0, 15)) | 4'b0110; end
      for (int k = 0; k < N_CH; k++) begin
        case ($urandom_range(0, 7))
          0, 1: dat[k] = 1001;
          2:    dat[k] = 1000;
          3, 4: dat[k] = -501;
          5:    dat[k] = -500;
          6:    dat[k] = 0;
          default: dat[k] = int'($urandom);
        endcase
      end
      rst = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end
    rst = 1;
    idle(3);
    @(posedge i_clk);
    #2;
    active = 0;
    if (q.size() != 0) chk("scoreboard_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/limit_intl_multi.md
# limit_intl_multi

Multi-channel, parametrised limit interlock with per-channel over/under setpoints, per-channel enables, persistence (debounce) counting and latched fault flags. It compares signed fixed-point samples in fabric, with no floating-point IP. It sits between the ADC/measurement path and the MPS interlock aggregator and replaces per-signal single-channel limit checkers. An optional first-fault capture is included.

## Interface
Parameters:
- `N_CH`, 4: number of monitored channels (1..32).
- `DW`, 32: sample and setpoint width, signed two's complement.
- `CW`, 8: persistence counter width.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, asynchronous, active-low.
- `i_data`  in  `N_CH*DW`  packed samples; channel k occupies bits [k*DW +: DW].
- `i_valid`  in  1  one-cycle strobe marking all channels of `i_data` as a new sample.
- `i_over_sp`  in  `N_CH*DW`  packed over-limit setpoints, same packing as `i_data`.
- `i_under_sp`  in  `N_CH*DW`  packed under-limit setpoints, same packing as `i_data`.
- `i_over_en`  in  `N_CH`  per-channel over-check enable.
- `i_under_en`  in  `N_CH`  per-channel under-check enable.
- `i_persist`  in  `CW`  number of consecutive violating samples required to trip; 0 is treated as 1.
- `i_clr`  in  1  clears latched flags and counters.
- `o_over_flag`  out  `N_CH`  latched over-limit faults.
- `o_under_flag`  out  `N_CH`  latched under-limit faults.
- `o_intl`  out  1  OR of all bits of `o_over_flag` and `o_under_flag`.
- `o_first_ch`  out  `$clog2(N_CH)` (minimum 1)  channel index of the first fault.
- `o_first_type`  out  1  type of the first fault: 1 = over, 0 = under.
- `o_first_valid`  out  1  first-fault record is valid.

## Operation
- Stage 1 (on `i_valid`):
  - Register `ov[k] = i_over_en[k] && (data_k > over_sp_k)` (signed, strict).
  - Register `un[k] = i_under_en[k] && (data_k < under_sp_k)` (signed, strict).
  - Register a 1-bit `s1_valid`.
  - A sample equal to a setpoint is not a violation.
- Stage 2 (on `s1_valid`), per channel and per direction:
  - Violation: the counter increments, saturating at `max(i_persist,1)`.
  - No violation: the counter resets to 0.
  - Flag sets when the counter's next value equals `max(i_persist,1)`.
- Flags are sticky. Only `i_clr` or reset clears them.
- Clearing an enable resets that direction's counter on the next valid sample. It does not clear an already latched flag.
- `i_clr` zeroes all counters and all flags not being set in the same cycle.
- Simultaneous set and `i_clr`: set wins and the flag stays 1. That direction's counter is zeroed.
- Changing `i_persist` mid-run does not reset counters. A counter above the new threshold trips on the next violating sample.
- `i_valid` gaps do not reset counters. Persistence counts valid samples, not clocks.
- Reset values: all flags 0, all counters 0, pipeline valid 0, `o_intl` 0, all first-fault outputs 0.
- Reset asserted mid-operation discards in-flight samples.

## Timing
- Latency: `i_valid` at cycle t → stage 1 registered at t+1 → flag visible at t+2 when `i_persist` ≤ 1.
- General case: the flag rises 2 cycles after the P-th consecutive violating valid sample.
- `o_intl` is combinational from the flag registers, so it has the same cycle as the flags.
- `i_clr` takes effect on the next edge: flags read 0 one cycle after `i_clr` is sampled.
- Back-to-back `i_valid` on every cycle is supported (throughput 1 sample/clk).

## Configuration
- Macro: `LIMIT_INTL_FIRST_FAULT_EN`.
- Defined:
  - Capture occurs in the cycle where any flag transitions 0→1 while `o_first_valid` = 0.
  - It records the lowest-index channel with a new flag. Over has priority over under on the same channel.
  - `o_first_valid` goes to 1. The record then holds.
  - `i_clr` clears the record unless a new flag sets in that same cycle, in which case the new fault is recorded.
- Undefined: `o_first_ch`, `o_first_type` and `o_first_valid` are tied 0, and no capture logic is built.

## Test plan
- `N_CH`=4, ch1 over_sp=1000, over_en=1, `i_persist`=1, data=1001 with `i_valid` → `o_over_flag`=4'b0010 and `o_intl`=1 exactly 2 clocks later. Data=1000 → no flag.
- ch0 under_sp=-500, `i_persist`=3. Samples -501, -501, -400, -501, -501, -501 → flag sets only after the 6th sample, at +2 clocks.
- Flag latched, data back in range, `i_clr` pulse → flags 0 next cycle. `i_clr` coincident with a trip sample → flag remains 1.
- Disable `i_over_en[2]` with a violating input → no flag and counter held at 0. Latched ch2 flag stays 1 after the disable.
- With `LIMIT_INTL_FIRST_FAULT_EN`: ch3 over and ch1 under trip in the same cycle → `o_first_ch`=1, `o_first_type`=0. A later ch0 trip does not change the record.
- Assert `i_rst` low with counters at 2/3 and a sample in flight → all outputs 0. After release the first violating sample does not trip.
